// File: rtl/dram_port_arbiter_pkg.sv
// Shared constants and helpers for the dram port arbiter.
// Command encoding and id-width sizing used by the top and the arbiter.
package dram_arb_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester command/response bus plus the dram port signals.
// The arbiter uses the slave view, clients/dram the master view.
interface dram_port_arbiter_if #(
    parameter int REQ_NUM = 4,
    parameter int WIDTH   = 4,
    parameter int ADDR    = 3,
    parameter int IDW     = 2
);
    logic [REQ_NUM-1:0]       req_valid_i;
    logic [REQ_NUM-1:0]       req_wr_i;
    logic [REQ_NUM*ADDR-1:0]  req_addr_i;
    logic [REQ_NUM*WIDTH-1:0] req_wdata_i;
    logic [REQ_NUM-1:0]       req_ready_o;
    logic                     rsp_valid_o;
    logic [IDW-1:0]           rsp_id_o;
    logic [WIDTH-1:0]         rsp_data_o;
    logic [ADDR-1:0]          mem_addr_o;
    logic                     mem_wr_en_o;
    logic [WIDTH-1:0]         mem_wr_data_o;
    logic                     mem_rd_en_o;
    logic [WIDTH-1:0]         mem_rd_data_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i,
        input  req_wdata_i, mem_rd_data_i,
        output req_ready_o, rsp_valid_o, rsp_id_o,
        output rsp_data_o, mem_addr_o, mem_wr_en_o,
        output mem_wr_data_o, mem_rd_en_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i,
        output req_wdata_i, mem_rd_data_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o,
        input  rsp_data_o, mem_addr_o, mem_wr_en_o,
        input  mem_wr_data_o, mem_rd_en_o
    );

endinterface

// File: rtl/dram_port_arbiter_rr.sv
// Weighted round-robin arbiter: a requester may keep the grant
// for up to HOLD consecutive beats before the pointer moves on.
module rr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int HOLD    = 1,
    parameter int IDW     = id_width(REQ_NUM)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [REQ_NUM-1:0] i_req,
    output logic [REQ_NUM-1:0] o_grant,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);
    localparam int HW = $clog2(HOLD + 1);

    logic [IDW-1:0] rr_ptr_r;
    logic [HW-1:0]  hold_cnt_r;
    logic [IDW:0]   w_j;
    logic           w_any;
    logic [IDW-1:0] w_idx;
    logic [HW-1:0]  w_n;

    // Circular scan starting at the pointer; held off during reset
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_j   = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            w_j = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (w_j >= (IDW+1)'(REQ_NUM))
                w_j = w_j - (IDW+1)'(REQ_NUM);
            if (!w_any && i_req[w_j[IDW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_j[IDW-1:0];
            end
        end
        if (i_rst)
            w_any = 1'b0;
    end

    assign w_n = ((w_idx == rr_ptr_r) ? hold_cnt_r : '0)
               + HW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
        end else if (w_any) begin
            if (w_n < HW'(HOLD)) begin
                rr_ptr_r   <= w_idx;
                hold_cnt_r <= w_n;
            end else begin
                rr_ptr_r   <= (w_idx == IDW'(REQ_NUM-1))
                            ? '0 : w_idx + 1'b1;
                hold_cnt_r <= '0;
            end
        end
    end

    assign o_any   = w_any;
    assign o_idx   = w_idx;
    assign o_grant = w_any ? (REQ_NUM'(1) << w_idx) : '0;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one dram port among REQ_NUM requesters: grant mux,
// registered command stage and a 2-deep read-id pipe.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter int ADDR    = $clog2(DEPTH),
    parameter int HOLD    = 1,
    parameter int IDW     = id_width(REQ_NUM)
) (
    input logic                clk_i,
    input logic                rst_i,
    dram_port_arbiter_if.slave bus
);
    logic [REQ_NUM-1:0] w_grant;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_wr;
    logic [ADDR-1:0]    w_addr;
    logic [WIDTH-1:0]   w_wdata;
    logic               w_is_wr;
    logic               w_is_rd;

    logic               r_wr_en;
    logic               r_rd_en;
    logic [ADDR-1:0]    r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_rv1;
    logic [IDW-1:0]     r_id1;
    logic               r_rsp_v;
    logic [IDW-1:0]     r_rsp_id;

    rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .HOLD    (HOLD),
        .IDW     (IDW)
    ) u_arb (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_req   (bus.req_valid_i),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign bus.req_ready_o = w_grant;

    assign w_wr    = bus.req_wr_i[w_idx];
    assign w_addr  = bus.req_addr_i[w_idx*ADDR +: ADDR];
    assign w_wdata = bus.req_wdata_i[w_idx*WIDTH +: WIDTH];
    assign w_is_wr = w_any && (w_wr == CMD_WR);
    assign w_is_rd = w_any && (w_wr == CMD_RD);

    // Idle beats and read beats drive zero address/data bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rv1    <= 1'b0;
            r_id1    <= '0;
            r_rsp_v  <= 1'b0;
            r_rsp_id <= '0;
        end else begin
            r_wr_en  <= w_is_wr;
            r_rd_en  <= w_is_rd;
            r_addr   <= w_any ? w_addr : '0;
            r_wdata  <= w_is_wr ? w_wdata : '0;
            r_rv1    <= w_is_rd;
            r_id1    <= w_is_rd ? w_idx : '0;
            r_rsp_v  <= r_rv1;
            r_rsp_id <= r_id1;
        end
    end

    assign bus.mem_wr_en_o   = r_wr_en;
    assign bus.mem_rd_en_o   = r_rd_en;
    assign bus.mem_addr_o    = r_addr;
    assign bus.mem_wr_data_o = r_wdata;
    assign bus.rsp_valid_o   = r_rsp_v;
    assign bus.rsp_id_o      = r_rsp_id;
    assign bus.rsp_data_o    = r_rsp_v ? bus.mem_rd_data_i : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: HOLD=1 and HOLD=2 instances share
// stimulus; each is compared against a transaction-level model.
module tb_dram_port_arbiter;
    localparam int RN = 4;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int A  = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [RN-1:0]   v;
    logic [RN-1:0]   wr;
    logic [RN*A-1:0] addr;
    logic [RN*W-1:0] wd;

    dram_port_arbiter_if #(
        .REQ_NUM(RN), .WIDTH(W), .ADDR(A), .IDW(IW)
    ) bus1 ();
    dram_port_arbiter_if #(
        .REQ_NUM(RN), .WIDTH(W), .ADDR(A), .IDW(IW)
    ) bus2 ();

    assign bus1.req_valid_i = v;
    assign bus1.req_wr_i    = wr;
    assign bus1.req_addr_i  = addr;
    assign bus1.req_wdata_i = wd;
    assign bus2.req_valid_i = v;
    assign bus2.req_wr_i    = wr;
    assign bus2.req_addr_i  = addr;
    assign bus2.req_wdata_i = wd;

    dram_port_arbiter #(
        .REQ_NUM(RN), .WIDTH(W), .DEPTH(D), .HOLD(1)
    ) u_h1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    dram_port_arbiter #(
        .REQ_NUM(RN), .WIDTH(W), .DEPTH(D), .HOLD(2)
    ) u_h2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    // Simple dram ports: registered read, cleared on reset
    logic [W-1:0] dm0 [D];
    logic [W-1:0] dm1 [D];
    logic [W-1:0] drd0;
    logic [W-1:0] drd1;
    assign bus1.mem_rd_data_i = drd0;
    assign bus2.mem_rd_data_i = drd1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drd0 <= '0;
            for (int i = 0; i < D; i++) dm0[i] <= '0;
        end else begin
            if (bus1.mem_wr_en_o)
                dm0[bus1.mem_addr_o] <= bus1.mem_wr_data_o;
            if (bus1.mem_rd_en_o)
                drd0 <= dm0[bus1.mem_addr_o];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drd1 <= '0;
            for (int i = 0; i < D; i++) dm1[i] <= '0;
        end else begin
            if (bus2.mem_wr_en_o)
                dm1[bus2.mem_addr_o] <= bus2.mem_wr_data_o;
            if (bus2.mem_rd_en_o)
                drd1 <= dm1[bus2.mem_addr_o];
        end
    end

    logic [RN-1:0] o_rdy [2];
    logic [8:0]    o_mem [2];
    logic [6:0]    o_rsp [2];
    assign o_rdy[0] = bus1.req_ready_o;
    assign o_rdy[1] = bus2.req_ready_o;
    assign o_mem[0] = {bus1.mem_wr_en_o, bus1.mem_rd_en_o,
                       bus1.mem_addr_o, bus1.mem_wr_data_o};
    assign o_mem[1] = {bus2.mem_wr_en_o, bus2.mem_rd_en_o,
                       bus2.mem_addr_o, bus2.mem_wr_data_o};
    assign o_rsp[0] = {bus1.rsp_valid_o, bus1.rsp_id_o,
                       bus1.rsp_data_o};
    assign o_rsp[1] = {bus2.rsp_valid_o, bus2.rsp_id_o,
                       bus2.rsp_data_o};

    // Reference model: arbitration state, memory image, pipelines
    int       m_ptr  [2];
    int       m_cnt  [2];
    int       m_hold [2] = '{1, 2};
    logic [W-1:0] m_mem [2][D];
    bit       c_v  [2];
    bit       c_wr [2];
    int       c_a  [2];
    int       c_d  [2];
    int       c_id [2];
    bit       q_v  [2];
    int       q_id [2];
    int       q_d  [2];

    logic [RN-1:0] last_rdy [2];
    logic [8:0]    last_mem [2];
    logic [6:0]    last_rsp [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int mgrant(input int ptr,
                                  input logic [RN-1:0] vv);
        for (int k = 0; k < RN; k++) begin
            int j;
            j = (ptr + k) % RN;
            if (vv[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_ptr[h] = 0;
            m_cnt[h] = 0;
            c_v[h]   = 1'b0;
            c_wr[h]  = 1'b0;
            c_a[h]   = 0;
            c_d[h]   = 0;
            c_id[h]  = 0;
            q_v[h]   = 1'b0;
            q_id[h]  = 0;
            q_d[h]   = 0;
            for (int i = 0; i < D; i++) m_mem[h][i] = '0;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    // One cycle: check at negedge, advance model, return after posedge
    task automatic step();
        @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            int            g;
            int            n;
            logic [RN-1:0] er;
            logic [8:0]    em;
            logic [8:0]    om;
            logic [6:0]    es;
            bit            nv;
            int            nid;
            int            nd;
            g  = rst ? -1 : mgrant(m_ptr[h], v);
            er = (g < 0) ? '0 : (RN'(1) << g);
            check($sformatf("ready_h%0d", h), 32'(o_rdy[h]), 32'(er));
            em = {c_v[h] && c_wr[h], c_v[h] && !c_wr[h],
                  c_v[h] ? A'(c_a[h]) : A'(0),
                  (c_v[h] && c_wr[h]) ? W'(c_d[h]) : W'(0)};
            om = o_mem[h];
            if (om[7]) om[3:0] = '0;
            check($sformatf("mem_h%0d", h), 32'(om), 32'(em));
            es = q_v[h] ? {1'b1, IW'(q_id[h]), W'(q_d[h])} : 7'd0;
            check($sformatf("rsp_h%0d", h), 32'(o_rsp[h]), 32'(es));
            last_rdy[h] = o_rdy[h];
            last_mem[h] = o_mem[h];
            last_rsp[h] = o_rsp[h];
            if (!rst) begin
                nv  = c_v[h] && !c_wr[h];
                nid = nv ? c_id[h] : 0;
                nd  = nv ? int'(m_mem[h][c_a[h]]) : 0;
                if (c_v[h] && c_wr[h])
                    m_mem[h][c_a[h]] = W'(c_d[h]);
                q_v[h]  = nv;
                q_id[h] = nid;
                q_d[h]  = nd;
                c_v[h]  = (g >= 0);
                if (g >= 0) begin
                    c_wr[h] = wr[g];
                    c_a[h]  = int'(addr[g*A +: A]);
                    c_d[h]  = int'(wd[g*W +: W]);
                    c_id[h] = g;
                    n = ((g == m_ptr[h]) ? m_cnt[h] : 0) + 1;
                    if (n < m_hold[h]) begin
                        m_ptr[h] = g;
                        m_cnt[h] = n;
                    end else begin
                        m_ptr[h] = (g + 1) % RN;
                        m_cnt[h] = 0;
                    end
                end
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    int exp1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp2 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin
        v    = '0;
        wr   = '0;
        addr = '0;
        wd   = '0;
        rst  = 1'b1;
        model_reset();
        #1;
        v = '1;
        step();
        step();
        check("rst_ready", 32'(last_rdy[0] | last_rdy[1]), 32'd0);
        rst = 1'b0;
        v   = '0;
        step();

        // Write 0xA @3 by req1, read it back the next cycle
        v  = 4'b0010;
        wr = 4'b0010;
        addr[1*A +: A] = 3'd3;
        wd[1*W +: W]   = 4'hA;
        step();
        wr = '0;
        step();
        check("wr_en_t1", 32'(last_mem[0]), 32'({2'b10, 3'd3, 4'hA}));
        v = '0;
        step();
        step();
        check("rsp_t3_h1", 32'(last_rsp[0]), 32'({1'b1, 2'd1, 4'hA}));
        check("rsp_t3_h2", 32'(last_rsp[1]), 32'({1'b1, 2'd1, 4'hA}));

        // All four reading: grant order per HOLD
        pulse_rst();
        v  = '1;
        wr = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("order_h1_%0d", i),
                  32'(last_rdy[0]), 32'(RN'(1) << exp1[i]));
            check($sformatf("order_h2_%0d", i),
                  32'(last_rdy[1]), 32'(RN'(1) << exp2[i]));
        end

        // Lone requester keeps going with HOLD=2
        pulse_rst();
        v = 4'b0100;
        step();
        check("solo_b0", 32'(last_rdy[1]), 32'h4);
        step();
        check("solo_b1", 32'(last_rdy[1]), 32'h4);
        check("solo_ptr", 32'(u_h2.u_arb.rr_ptr_r), 32'd3);
        step();
        check("solo_b2", 32'(last_rdy[1]), 32'h4);

        // Read in flight is dropped by reset
        pulse_rst();
        v  = 4'b0001;
        wr = '0;
        step();
        v = '0;
        pulse_rst();
        step();
        check("rstrd_mem", 32'(last_mem[0]), 32'd0);
        step();
        check("rstrd_rsp", 32'(last_rsp[0] | last_rsp[1]), 32'd0);
        v = '1;
        step();
        check("rstrd_g0", 32'(last_rdy[0]), 32'h1);

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_rst();
            v    = RN'($urandom);
            wr   = RN'($urandom);
            addr = (RN*A)'($urandom);
            wd   = (RN*W)'($urandom);
            step();
        end
        v = '0;
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
